// File: rtl/sig_edge_logger.sv
// sig_edge_logger: watches Delay_sig_in, timestamps every value change with a
// free-running counter and queues {value, ts} records in a small FIFO with a
// valid/ready drain port. A change that arrives while the FIFO is full and not
// being drained is dropped and latches a sticky overflow flag.
// Optional feature macro: GLITCH_FILTER_EN (a new value must be stable for
// FILT_CYC consecutive edges before it counts as a change).
module sig_edge_logger #(
  parameter int Nbits    = 3,
  parameter int TS_W     = 8,
  parameter int DEPTH    = 4,
  parameter int FILT_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Nbits-1:0] Delay_sig_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [Nbits-1:0] evt_value,
  output logic [TS_W-1:0]  evt_ts,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [Nbits-1:0] value;
    logic [TS_W-1:0]  ts;
  } evt_t;

  logic [TS_W-1:0]  ts_cnt;
  logic [Nbits-1:0] last_val;
  evt_t             mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             change, full, pop, do_push, drop;

`ifdef GLITCH_FILTER_EN
  logic [Nbits-1:0] cand;
  logic [3:0]       stab, stab_nxt;

  // Length of the current run of identical samples, including this edge.
  always_comb begin
    stab_nxt = 4'd1;
    if (Delay_sig_in == cand)
      stab_nxt = (stab == 4'hF) ? stab : stab + 4'd1;
  end

  // Accept only once the run reaches FILT_CYC; a return to last_val is silent.
  assign change = (Delay_sig_in != last_val) && (stab_nxt >= 4'(FILT_CYC));

  // Track the candidate value and its stability run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      stab <= '0;
    end else begin
      cand <= Delay_sig_in;
      stab <= stab_nxt;
    end
  end
`else
  assign change = (Delay_sig_in != last_val);
`endif

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = evt_valid && evt_ready;
  assign do_push = change && (!full || pop);
  assign drop    = change && full && !pop;

  // Head is gated so the outputs read zero whenever the FIFO is empty.
  assign evt_valid = (count != '0);
  assign evt_value = evt_valid ? mem[rd_ptr].value : '0;
  assign evt_ts    = evt_valid ? mem[rd_ptr].ts    : '0;

  // Timestamp counter and last accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt   <= '0;
      last_val <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (change) last_val <= Delay_sig_in;
    end
  end

  // Event storage; a full+pop edge overwrites the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= '{value: Delay_sig_in, ts: ts_cnt};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop wins over a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_sig_edge_logger.sv
// Directed bench for sig_edge_logger (default parameters).
module tb_sig_edge_logger;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sig;
  logic       rdy, clr;
  logic       evt_valid, overflow;
  logic [2:0] evt_value;
  logic [7:0] evt_ts;

  int checks = 0;
  int errors = 0;

  sig_edge_logger dut (
    .clk(clk), .rst_n(rst_n), .Delay_sig_in(sig), .evt_ready(rdy),
    .ovf_clr(clr), .evt_valid(evt_valid), .evt_value(evt_value),
    .evt_ts(evt_ts), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sig;
    logic       rdy;
    logic       clr;
    logic       vld;
    logic [2:0] val;
    logic [7:0] ts;
    logic       ovf;
  } vec_t;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input int idx, input logic v, input logic [2:0] val,
                         input logic [7:0] ts, input logic o);
    chk("evt_valid", idx, 32'(evt_valid), 32'(v));
    chk("evt_value", idx, 32'(evt_value), 32'(val));
    chk("evt_ts",    idx, 32'(evt_ts),    32'(ts));
    chk("overflow",  idx, 32'(overflow),  32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset now, release it before the next posedge (that edge is edge 0).
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [17];

  initial begin
    rst_n = 1'b0; sig = '0; rdy = 1'b0; clr = 1'b0;
    #3;
    chk_out(-1, 1'b0, 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef GLITCH_FILTER_EN
    // Expected outputs after the edge at which the row is applied (row i = edge i).
    tbl[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0}; // no change
    tbl[1]  = '{3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1,  1'b0}; // ev {1,1}
    tbl[2]  = '{3'd2, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1,  1'b0}; // ev {2,2}
    tbl[3]  = '{3'd3, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1,  1'b0}; // ev {3,3}
    tbl[4]  = '{3'd4, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1,  1'b0}; // ev {4,4}, full
    tbl[5]  = '{3'd5, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1,  1'b1}; // dropped
    tbl[6]  = '{3'd6, 1'b0, 1'b1, 1'b1, 3'd1, 8'd1,  1'b1}; // drop beats clear
    tbl[7]  = '{3'd6, 1'b0, 1'b1, 1'b1, 3'd1, 8'd1,  1'b0}; // clear
    tbl[8]  = '{3'd7, 1'b1, 1'b0, 1'b1, 3'd2, 8'd2,  1'b0}; // full push+pop {7,8}
    tbl[9]  = '{3'd7, 1'b1, 1'b0, 1'b1, 3'd3, 8'd3,  1'b0};
    tbl[10] = '{3'd7, 1'b1, 1'b0, 1'b1, 3'd4, 8'd4,  1'b0};
    tbl[11] = '{3'd7, 1'b1, 1'b0, 1'b1, 3'd7, 8'd8,  1'b0}; // tail of full push
    tbl[12] = '{3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 8'd8,  1'b0}; // ev {0,12}
    tbl[13] = '{3'd1, 1'b1, 1'b0, 1'b1, 3'd0, 8'd12, 1'b0}; // push+pop {1,13}
    tbl[14] = '{3'd1, 1'b1, 1'b0, 1'b1, 3'd1, 8'd13, 1'b0};
    tbl[15] = '{3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0}; // empty
    tbl[16] = '{3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0,  1'b0}; // ready while empty
    for (int i = 0; i < 17; i++) begin
      sig = tbl[i].sig; rdy = tbl[i].rdy; clr = tbl[i].clr;
      tick();
      chk_out(i, tbl[i].vld, tbl[i].val, tbl[i].ts, tbl[i].ovf);
    end
`else
    // FILT_CYC=2: single-cycle pulse is ignored, a held value is accepted late.
    begin
      logic [2:0] fs [8] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3};
      for (int i = 0; i < 8; i++) begin
        sig = fs[i];
        tick();
        if (i < 7) chk("filt_valid", i, 32'(evt_valid), 32'd0);
      end
      chk_out(7, 1'b1, 3'd3, 8'd7, 1'b0);
      sig = 3'd1; tick(); tick(); // queue {1,9}
    end
`endif

    // Three events queued, then an asynchronous reset mid-cycle.
    rdy = 1'b0; clr = 1'b0;
    sig = 3'd2; tick(); tick();
    sig = 3'd4; tick(); tick();
    sig = 3'd6; tick(); tick();
    chk("pre_rst_valid", 100, 32'(evt_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out(101, 1'b0, 3'd0, 8'd0, 1'b0);
    sig = 3'd3;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`ifndef GLITCH_FILTER_EN
    chk_out(102, 1'b1, 3'd3, 8'd0, 1'b0);
`else
    chk("post_rst_e0", 102, 32'(evt_valid), 32'd0);
    tick();
    chk_out(103, 1'b1, 3'd3, 8'd1, 1'b0);
`endif
    rdy = 1'b1; sig = 3'd3;
    tick();
    chk("post_rst_drain", 104, 32'(evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sig_edge_logger.md
SIG_EDGE_LOGGER -- requirements
Module: sig_edge_logger

Interface
REQ-001 Parameter Nbits, default 3, width of the monitored signal bus.
REQ-002 Parameter TS_W, default 8, width of the free-running timestamp counter.
REQ-003 Parameter DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-004 Parameter FILT_CYC, default 2, glitch-filter stability length in cycles, 1..15; used only when GLITCH_FILTER_EN is defined.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 Delay_sig_in  input  Nbits  delayed signal from the upstream delay stage, synchronous to clk.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 ovf_clr  input  1  clears the overflow flag.
REQ-010 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-011 evt_value  output  Nbits  new signal value of the head event.
REQ-012 evt_ts  output  TS_W  timestamp of the head event.
REQ-013 overflow  output  1  sticky: at least one event was dropped.

Function
REQ-014 Free-running counter ts_cnt SHALL increment every edge, wrapping 2^TS_W-1 -> 0; an event's timestamp is ts_cnt before that edge's increment.
REQ-015 Register last_val holds the last accepted value; a change event SHALL occur at an edge where the accepted input differs from last_val.
REQ-016 On a change event, last_val SHALL update to the new value at that edge, whether or not the event is stored.
REQ-017 Stored record = {value, timestamp}; written into the FIFO at the event edge; evt_valid SHALL rise in the cycle after that edge (1-cycle latency, no combinational bypass).
REQ-018 Handshake: pop SHALL occur on an edge where evt_valid and evt_ready are both 1; evt_value/evt_ts SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-019 evt_ready while empty SHALL have no effect.
REQ-020 Full, with push and no pop: the event SHALL be dropped, FIFO unchanged, overflow set at that edge.
REQ-021 Full, with simultaneous push and pop: both SHALL occur, and overflow SHALL NOT be set.
REQ-022 Non-full, with simultaneous push and pop: occupancy SHALL be unchanged, and ordering SHALL be preserved.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a log2(DEPTH)+1-bit count.
REQ-024 overflow SHALL clear on an edge with ovf_clr=1 unless a drop occurs on the same edge; a drop SHALL take priority.

Reset
REQ-025 rst_n=0 SHALL immediately force: ts_cnt=0, last_val=0, FIFO empty, evt_valid=0, evt_value=0, evt_ts=0, overflow=0, filter state cleared.
REQ-026 Reset asserted mid-operation SHALL discard all queued events; no event is generated for the reset itself.
REQ-027 The first posedge after rst_n deasserts SHALL be edge 0, with ts_cnt=0.

Configuration
REQ-028 Macro GLITCH_FILTER_EN.
REQ-029 Defined: a new value is accepted only after it is sampled identically on FILT_CYC consecutive edges; the event is generated on the last of those edges and timestamped there. Any intervening change restarts the count. A return to last_val before acceptance SHALL produce no event.
REQ-030 Undefined: Delay_sig_in SHALL be accepted on every edge (REQ-015 applied directly); no filter logic is present, and FILT_CYC is ignored.

Verification
REQ-031 Filter off: input 000 on edges 0-2, 010 from edge 3 -> one event {010, ts=3}; evt_valid=1 after edge 3.
REQ-032 Filter off, DEPTH=4, evt_ready=0: five changes on edges 1-5 -> four events held; overflow=1 after edge 5; draining yields ts 1,2,3,4 in order.
REQ-033 Full FIFO, evt_ready=1 while a change arrives on the same edge -> count stays 4, overflow stays 0, new event at tail.
REQ-034 ovf_clr=1 on the same edge as a drop -> overflow=1; ovf_clr=1 on a later edge with no drop -> overflow=0.
REQ-035 GLITCH_FILTER_EN, FILT_CYC=2: one-cycle pulse 000->100->000 -> no event; 000->011 held from edge 6 -> event {011, ts=7}.
REQ-036 rst_n pulsed low asynchronously with 3 events queued -> evt_valid=0 and overflow=0 immediately; after release, the first event carries ts from 0.
